// File: rtl/apb_intercon_rr_pkg.sv
// Shared definitions for the round-robin APB interconnect: FSM encoding,
// the default peripheral address map and a small pointer helper.
package apb_intercon_pkg;

  // Sequencer states; IDLE is revisited between every transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam int DEF_BUS_WIDTH    = 16;
  localparam int DEF_MASTER_PORTS = 4;
  localparam int DEF_SLAVE_PORTS  = 5;

  // Default peripheral map, inclusive base/limit per window.
  localparam logic [15:0] GPIO_BASE  = 16'h0080;
  localparam logic [15:0] GPIO_LIMIT = 16'h008F;
  localparam logic [15:0] UART_BASE  = 16'h0090;
  localparam logic [15:0] UART_LIMIT = 16'h009F;
  localparam logic [15:0] TIMR_BASE  = 16'h00A0;
  localparam logic [15:0] TIMR_LIMIT = 16'h00AF;
  localparam logic [15:0] REGS_BASE  = 16'h00B0;
  localparam logic [15:0] REGS_LIMIT = 16'h00B1;
  localparam logic [15:0] SEM_BASE   = 16'h00C0;
  localparam logic [15:0] SEM_LIMIT  = 16'h00C0;

  // Packed maps, slave 0 in the least significant slice.
  localparam logic [79:0] DEF_SLAVE_BASE  = {SEM_BASE, REGS_BASE, TIMR_BASE, UART_BASE, GPIO_BASE};
  localparam logic [79:0] DEF_SLAVE_LIMIT = {SEM_LIMIT, REGS_LIMIT, TIMR_LIMIT, UART_LIMIT, GPIO_LIMIT};

  // Index following idx in a ring of n entries.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_intercon_rr_if.sv
// Bus bundle for the interconnect: core-side S_* ports and peripheral-side M_*.
// The "master" modport is the interconnect's own view (it masters the
// peripheral bus); "slave" is the surrounding environment's view.
interface apb_intercon_rr_if
  import apb_intercon_pkg::*;
#(
  parameter int MASTER_PORTS = DEF_MASTER_PORTS,
  parameter int SLAVE_PORTS  = DEF_SLAVE_PORTS,
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH
);
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]           S_PWRITE;
  logic [MASTER_PORTS-1:0]           S_PSELx;
  logic [MASTER_PORTS-1:0]           S_PENABLE;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]           S_PREADY;
  logic [MASTER_PORTS-1:0]           S_PSLVERR;
  logic [BUS_WIDTH-1:0]              M_PADDR;
  logic                              M_PWRITE;
  logic [SLAVE_PORTS-1:0]            M_PSELx;
  logic                              M_PENABLE;
  logic [BUS_WIDTH-1:0]              M_PWDATA;
  logic [BUS_WIDTH-1:0]              M_PRDATA;
  logic                              M_PREADY;

  modport master (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

  modport slave (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );
endinterface

// File: rtl/apb_intercon_rr_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping past the top. The pointer itself lives in the parent.
module rr_arbiter
  import apb_intercon_pkg::*;
#(
  parameter int N     = DEF_MASTER_PORTS,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_valid
);

  // Scan offsets from highest to lowest so the smallest offset is the final winner.
  always_comb begin
    int idx;
    idx     = 0;
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_req[idx]) begin
        o_grant = IDX_W'(idx);
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/apb_intercon_rr.sv
// Multi-master APB interconnect: round-robin arbitration of core masters onto
// one peripheral bus, base/limit slave decode, registered SETUP/ACCESS
// sequencing, decode-error response and an ACCESS-phase timeout.
module apb_intercon_rr
  import apb_intercon_pkg::*;
#(
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int MASTER_PORTS = DEF_MASTER_PORTS,
  parameter int SLAVE_PORTS  = DEF_SLAVE_PORTS,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE  = DEF_SLAVE_BASE,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_LIMIT = DEF_SLAVE_LIMIT,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  apb_intercon_rr_if.master bus
);

  localparam int IDX_W   = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                            r_state;
  state_t                            w_next_state;
  logic [IDX_W-1:0]                  r_grant;
  logic [IDX_W-1:0]                  r_ptr;
  logic [TIMER_W-1:0]                r_timer;
  logic [BUS_WIDTH-1:0]              r_paddr;
  logic [BUS_WIDTH-1:0]              r_pwdata;
  logic                              r_pwrite;
  logic [SLAVE_PORTS-1:0]            r_psel;
  logic                              r_penable;
  logic                              r_miss;

  logic [IDX_W-1:0]                  w_arb_grant;
  logic                              w_arb_valid;
  logic [BUS_WIDTH-1:0]              w_req_addr;
  logic [SLAVE_PORTS-1:0]            w_hit;
  logic                              w_miss;
  logic                              w_access;
  logic                              w_done;
  logic                              w_timeout;
  logic                              w_err;
  logic                              w_finish;
  logic [IDX_W-1:0]                  w_next_ptr;
  logic [MASTER_PORTS-1:0]           w_s_pready;
  logic [MASTER_PORTS-1:0]           w_s_pslverr;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] w_s_prdata;
  logic                              w_unused_penable;

  rr_arbiter #(
    .N     (MASTER_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (bus.S_PSELx),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // PENABLE from the cores plays no part in arbitration.
  assign w_unused_penable = ^bus.S_PENABLE;

  assign w_req_addr = bus.S_PADDR[w_arb_grant*BUS_WIDTH +: BUS_WIDTH];
  assign w_next_ptr = IDX_W'(next_index(int'(r_grant), MASTER_PORTS));

  // Address decode of the winning request; the lowest matching window wins.
  always_comb begin
    w_hit = '0;
    for (int j = SLAVE_PORTS - 1; j >= 0; j--) begin
      if ((w_req_addr >= SLAVE_BASE[j*BUS_WIDTH +: BUS_WIDTH]) &&
          (w_req_addr <= SLAVE_LIMIT[j*BUS_WIDTH +: BUS_WIDTH])) begin
        w_hit    = '0;
        w_hit[j] = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign w_miss = (w_hit == '0);

  // Completion is suppressed while reset is asserted so an abandoned transfer never pulses.
  assign w_access  = (r_state == ACCESS) && !reset;
  assign w_done    = w_access && bus.M_PREADY;
  assign w_timeout = w_access && !bus.M_PREADY && (TIMEOUT != 0) &&
                     (r_timer == TIMER_W'(TIMEOUT - 1));
  assign w_err     = (r_state == ERR) && !reset;
  assign w_finish  = w_done || w_timeout || w_err;

  // Next-state selection for the IDLE/SETUP/ACCESS/ERR sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_next_state = SETUP;  else w_next_state = IDLE;
      SETUP:   if (r_miss)      w_next_state = ERR;    else w_next_state = ACCESS;
      ACCESS:  if (w_finish)    w_next_state = IDLE;   else w_next_state = ACCESS;
      ERR:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Completion pulse, error flag and read data routed to the granted master only.
  always_comb begin
    w_s_pready  = '0;
    w_s_pslverr = '0;
    w_s_prdata  = '0;
    if (w_finish) begin
      w_s_pready[r_grant]  = 1'b1;
      w_s_pslverr[r_grant] = w_timeout || w_err;
      if (w_done) begin
        w_s_prdata[r_grant*BUS_WIDTH +: BUS_WIDTH] = bus.M_PRDATA;
      end else begin
        w_s_prdata = '0;
      end
    end else begin
      w_s_pready = '0;
    end
  end

  // Sequencer state, round-robin pointer, timer and registered peripheral-bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          r_timer   <= '0;
          r_penable <= 1'b0;
          if (w_arb_valid) begin
            r_grant  <= w_arb_grant;
            r_paddr  <= w_req_addr;
            r_pwdata <= bus.S_PWDATA[w_arb_grant*BUS_WIDTH +: BUS_WIDTH];
            r_pwrite <= bus.S_PWRITE[w_arb_grant];
            r_psel   <= w_hit;
            r_miss   <= w_miss;
          end
        end
        SETUP: begin
          r_timer   <= '0;
          r_penable <= !r_miss;
        end
        ACCESS: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (w_finish) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ptr     <= w_next_ptr;
          end
        end
        ERR: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_ptr     <= w_next_ptr;
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.M_PADDR   = r_paddr;
  assign bus.M_PWDATA  = r_pwdata;
  assign bus.M_PWRITE  = r_pwrite;
  assign bus.M_PSELx   = r_psel;
  assign bus.M_PENABLE = r_penable;
  assign bus.S_PREADY  = w_s_pready;
  assign bus.S_PSLVERR = w_s_pslverr;
  assign bus.S_PRDATA  = w_s_prdata;

endmodule

// File: doc/apb_intercon_rr.md
Name: apb_intercon_rr

Overview:
- Parametrised multi-master APB interconnect; successor to the single-pass-through core/peripheral interconnect.
- Arbitrates N core-side APB masters onto one shared slave bus with round-robin fairness.
- Decodes the slave select from a parametrised base/limit address map.
- Adds a registered SETUP/ACCESS sequencer, decode-error response and an ACCESS-phase timeout.
- Sits between the core APB ports and the peripheral bus (GPIO, UART, timers, regs, semaphores).

Parameters:
- BUS_WIDTH, 16: address/data width.
- MASTER_PORTS, 4: number of requesting masters (1..16).
- SLAVE_PORTS, 5: number of slave selects.
- SLAVE_BASE, {16'hC0,16'hB0,16'hA0,16'h90,16'h80}: packed inclusive base per slave; slave 0 in the LSBs.
- SLAVE_LIMIT, {16'hC0,16'hB1,16'hAF,16'h9F,16'h8F}: packed inclusive limit per slave.
- TIMEOUT, 255: max ACCESS cycles waiting for M_PREADY; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  master addresses, master i at slice i
- S_PWRITE  in  MASTER_PORTS  write strobe per master
- S_PSELx  in  MASTER_PORTS  request per master; held until that master's S_PREADY
- S_PENABLE  in  MASTER_PORTS  accepted, ignored for arbitration
- S_PWDATA  in  MASTER_PORTS*BUS_WIDTH  write data per master
- S_PRDATA  out  MASTER_PORTS*BUS_WIDTH  read data; only the granted slice is non-zero
- S_PREADY  out  MASTER_PORTS  one-cycle completion pulse to the granted master
- S_PSLVERR  out  MASTER_PORTS  error flag, valid with S_PREADY
- M_PADDR  out  BUS_WIDTH  registered address
- M_PWRITE  out  1  registered write strobe
- M_PSELx  out  SLAVE_PORTS  one-hot decoded select
- M_PENABLE  out  1  high in ACCESS
- M_PWDATA  out  BUS_WIDTH  registered write data
- M_PRDATA  in  BUS_WIDTH  shared slave read data
- M_PREADY  in  1  shared slave ready

Behaviour:
- Clock and reset:
  - Single clock clk. Reset is synchronous and active-high.
  - On reset: state=IDLE, rr_ptr=0, grant=0, timer=0.
  - All outputs are 0 during and after reset until the first grant.
- Reset mid-transfer:
  - Abandons the transfer; no S_PREADY is issued.
  - M_PSELx and M_PENABLE drop in the following cycle.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE: if |S_PSELx, pick the first requester scanning from rr_ptr upward, with wrap.
    - Latch grant, and register M_PADDR, M_PWDATA and M_PWRITE from the grant slice.
    - Register decode hit[] and miss.
    - Go to SETUP.
  - SETUP: if miss, go to ERR. Otherwise drive M_PSELx=hit, M_PENABLE=0, and go to ACCESS.
  - ACCESS: M_PSELx held, M_PENABLE=1, timer increments.
    - On M_PREADY: S_PREADY[grant]=1 combinationally and S_PRDATA slice grant = M_PRDATA.
    - Same cycle: rr_ptr=(grant+1) mod MASTER_PORTS; go to IDLE.
    - On timer==TIMEOUT-1 with no M_PREADY (TIMEOUT>0): S_PREADY[grant]=1, S_PSLVERR[grant]=1, S_PRDATA=0; advance rr_ptr; go to IDLE.
  - ERR (decode miss): M_PSELx=0. For one cycle: S_PREADY[grant]=1, S_PSLVERR[grant]=1, S_PRDATA=0. Advance rr_ptr; go to IDLE.
- Decode: hit[j] = (addr >= BASE[j]) && (addr <= LIMIT[j]). Lowest j wins on overlap, so M_PSELx is always one-hot or zero.
- Latency:
  - Request seen in IDLE at cycle N; SETUP at N+1; ACCESS at N+2.
  - Earliest S_PREADY is at N+2 (zero-wait slave). Minimum period is 3 cycles per transfer.
  - Back-to-back transfers: IDLE is revisited between every transfer.
- Arbitration:
  - Simultaneous requests are served in rr_ptr order.
  - A continuously requesting master waits at most MASTER_PORTS-1 transfers.
- Non-granted masters: S_PREADY, S_PSLVERR and S_PRDATA are all 0.
- Granted master dropping S_PSELx mid-transfer: the slave transfer still completes and the pulse is still issued; no abort.
- M_PRDATA is ignored outside ACCESS.

Decomposition:
- Package apb_intercon_pkg: FSM state encoding (IDLE, SETUP, ACCESS, ERR) and default address-map constants (GPIO 0x80-0x8F, UART 0x90-0x9F, TIMR 0xA0-0xAF, REGS 0xB0-0xB1, SEM 0xC0).
- Sub-module rr_arbiter: inputs req[MASTER_PORTS] and ptr; outputs grant index and valid. Purely combinational; the pointer is registered in the parent.

Test Plan:
- Single master 0 reads 0x91, slave answers M_PREADY at first ACCESS with M_PRDATA=16'hBEEF -> M_PSELx=5'b00010 at N+1, M_PENABLE at N+2, S_PREADY[0] and S_PRDATA[15:0]=BEEF at N+2.
- All 4 masters request from reset, zero-wait slave -> grants in order 0,1,2,3, each S_PREADY spaced 3 cycles; master 0 re-requesting is served after master 3.
- Master 2 writes 0xB0 with PWDATA=16'h1234, slave waits 3 cycles -> M_PWDATA=1234 and M_PWRITE=1 stable throughout; S_PREADY[2] in the cycle M_PREADY rises.
- Master 1 accesses unmapped 0x40 -> M_PSELx stays 0, S_PREADY[1]=S_PSLVERR[1]=1 at N+2, S_PRDATA=0.
- TIMEOUT=4, slave never ready -> S_PSLVERR[0] pulses on the 4th ACCESS cycle, then the next requester is granted.
- Reset asserted during ACCESS -> next cycle all outputs 0, no S_PREADY; after release, master 0 is granted first (rr_ptr=0).
